ain_debouncer: RTL and testbench

//  Upstream stage of the Moore state machine: conditions the 2-bit raw input code into the

---
 rtl/ain_debouncer.sv | 69 ++++++
 tb/tb_ain_debouncer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ain_debouncer.sv
// ain_debouncer: 2-flop synchronizer plus whole-vector debounce of a 2-bit raw code.
// Optional AIN_GLITCH_COUNT_EN adds a saturating glitch_cnt output.
module ain_debouncer #(
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] raw_in,
    output logic [1:0] ain,
    output logic       ain_changed,
`ifdef AIN_GLITCH_COUNT_EN
    output logic [7:0] glitch_cnt,
`endif
    output logic       busy
);
    typedef enum logic {IDLE, CHECK} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    state_t           state;
    logic [1:0]       sync_q1, sync_q2, cand;
    logic [CNT_W-1:0] cnt;
    assign busy = (state == CHECK);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q1     <= 2'b00;
            sync_q2     <= 2'b00;
            ain         <= 2'b00;
            cand        <= 2'b00;
            cnt         <= '0;
            ain_changed <= 1'b0;
            state       <= IDLE;
        end else begin
            sync_q1     <= raw_in;
            sync_q2     <= sync_q1;
            ain_changed <= 1'b0;
            if (state == IDLE) begin
                if (sync_q2 != ain) begin
                    cand  <= sync_q2;
                    cnt   <= CNT_W'(1);
                    state <= CHECK;
                end
            end else if (sync_q2 == cand && cnt == CNT_MAX) begin
                ain         <= cand;
                ain_changed <= 1'b1;
                cnt         <= '0;
                state       <= IDLE;
            end else if (sync_q2 == cand) begin
                cnt <= cnt + 1'b1;
            end else if (sync_q2 == ain) begin
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cand <= sync_q2;
                cnt  <= CNT_W'(1);
            end
        end
    end
`ifdef AIN_GLITCH_COUNT_EN
    // any CHECK cycle that departs from the candidate is a bounce-back or a restart
    logic glitch_ev;
    assign glitch_ev = (state == CHECK) && (sync_q2 != cand);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            glitch_cnt <= 8'h00;
        else if (glitch_ev && glitch_cnt != 8'hFF)
            glitch_cnt <= glitch_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_ain_debouncer.sv
// tb_ain_debouncer: directed vectors; expected accepts go into a queue checked by a monitor.
`timescale 1ns/100ps
module tb_ain_debouncer;
    localparam int DEB = 4;
    typedef struct {logic [1:0] code; int cyc;} exp_t;
    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] raw_in;
    logic [1:0] ain;
    logic       ain_changed;
    logic       busy;
`ifdef AIN_GLITCH_COUNT_EN
    logic [7:0] glitch_cnt;
    logic [7:0] g0;
`endif
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    ain_debouncer #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock(clock),
        .reset(reset),
        .raw_in(raw_in),
        .ain(ain),
        .ain_changed(ain_changed),
`ifdef AIN_GLITCH_COUNT_EN
        .glitch_cnt(glitch_cnt),
`endif
        .busy(busy)
    );

    always #3 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // first sample edge is cyc+1, accept lands DEB+2 edges later
    task automatic expect_code(input logic [1:0] code);
        exp_t e;
        e.code = code;
        e.cyc  = cyc + 3 + DEB;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (ain_changed) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ain_changed", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("accept_code", int'(ain), int'(e.code));
                chk("accept_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int bc, n01;
        // 1. reset and first acceptance
        reset  = 1'b0;
        raw_in = 2'b11;
        #1;
        chk("rst_ain", int'(ain), 0);
        chk("rst_changed", int'(ain_changed), 0);
        chk("rst_busy", int'(busy), 0);
        #2.5;
        chk("rst_hold_ain", int'(ain), 0);
        chk("rst_hold_busy", int'(busy), 0);
        #0.5;
        reset = 1'b1;
        expect_code(2'b11);
        repeat (12) @(negedge clock);
        chk("t1_ain", int'(ain), 3);
        // 2. clean step
        raw_in = 2'b00;
        expect_code(2'b00);
        repeat (12) @(negedge clock);
        raw_in = 2'b01;
        expect_code(2'b01);
        bc = 0;
        repeat (20) begin
            @(negedge clock);
            bc += int'(busy);
        end
        chk("t2_busy_cycles", bc, DEB);
        chk("t2_ain", int'(ain), 1);
        // 3. short glitch
`ifdef AIN_GLITCH_COUNT_EN
        g0 = glitch_cnt;
`endif
        raw_in = 2'b10;
        repeat (2) @(negedge clock);
        raw_in = 2'b01;
        repeat (12) @(negedge clock);
        chk("t3_ain", int'(ain), 1);
        chk("t3_busy", int'(busy), 0);
`ifdef AIN_GLITCH_COUNT_EN
        chk("t3_glitch", int'(glitch_cnt - g0), 1);
`endif
        // 4. staggered bits
        raw_in = 2'b00;
        expect_code(2'b00);
        repeat (12) @(negedge clock);
`ifdef AIN_GLITCH_COUNT_EN
        g0 = glitch_cnt;
`endif
        raw_in = 2'b01;
        repeat (2) @(negedge clock);
        raw_in = 2'b11;
        expect_code(2'b11);
        n01 = 0;
        repeat (14) begin
            @(negedge clock);
            n01 += int'(ain == 2'b01);
        end
        chk("t4_no_01", n01, 0);
        chk("t4_ain", int'(ain), 3);
`ifdef AIN_GLITCH_COUNT_EN
        chk("t4_glitch", int'(glitch_cnt - g0), 1);
`endif
        // 5. reset on the second CHECK cycle
        raw_in = 2'b10;
        repeat (4) @(negedge clock);
        chk("t5_busy_before", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("t5_ain", int'(ain), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_changed", int'(ain_changed), 0);
        @(negedge clock);
        reset = 1'b1;
        expect_code(2'b10);
        repeat (12) @(negedge clock);
        chk("t5_requal_ain", int'(ain), 2);
`ifdef AIN_GLITCH_COUNT_EN
        // 6. saturation via repeated restarts
        for (int i = 0; i < 300; i++) begin
            raw_in = i[0] ? 2'b11 : 2'b01;
            if (i == 299) expect_code(2'b11);
            @(negedge clock);
        end
        repeat (12) @(negedge clock);
        chk("t6_glitch_sat", int'(glitch_cnt), 255);
        chk("t6_ain", int'(ain), 3);
`endif
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
